// File: rtl/control_contador_fases.sv
// rtl/control_contador_fases.sv - phase sequencer driving an external loadable 6-bit up-counter
// Four phases of programmable tick length; optional looping after phase 3.
module control_contador_fases (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       tick,
   input  logic       hold,
   input  logic       loop,
   input  logic [5:0] dur0,
   input  logic [5:0] dur1,
   input  logic [5:0] dur2,
   input  logic [5:0] dur3,
   input  logic [5:0] cnt_in,
   output logic       cnt_load,
   output logic [5:0] cnt_data,
   output logic       cnt_enable,
   output logic [1:0] phase,
   output logic       busy,
   output logic       phase_done,
   output logic       cycle_done
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t     state, state_next;
   logic [1:0] phase_next;
   logic [5:0] limit, limit_next;
   logic [5:0] dur_sel;
   logic       at_limit;

   assign cnt_data = 6'd0;
   assign at_limit = (cnt_in == limit);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         phase <= 2'd0;
         limit <= 6'd0;
      end else begin
         state <= state_next;
         phase <= phase_next;
         limit <= limit_next;
      end
   end

   always_comb begin
      case (phase)
         2'd0:    dur_sel = dur0;
         2'd1:    dur_sel = dur1;
         2'd2:    dur_sel = dur2;
         default: dur_sel = dur3;
      endcase
   end

   always_comb begin
      state_next = state;
      phase_next = phase;
      limit_next = limit;
      cnt_load   = 1'b0;
      cnt_enable = 1'b0;
      busy       = 1'b0;
      phase_done = 1'b0;
      cycle_done = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_next = LOAD;
               phase_next = 2'd0;
            end
         end
         LOAD: begin
            busy       = 1'b1;
            cnt_load   = 1'b1;
            limit_next = dur_sel;
            state_next = RUN;
         end
         RUN: begin
            busy       = 1'b1;
            cnt_enable = tick & ~hold & ~at_limit;
            // Phase end is judged on the counter value alone, so hold cannot stretch it.
            if (at_limit) begin
               phase_done = 1'b1;
               if (phase == 2'd3) begin
                  cycle_done = 1'b1;
                  phase_next = 2'd0;
                  state_next = loop ? LOAD : IDLE;
               end else begin
                  phase_next = phase + 2'd1;
                  state_next = LOAD;
               end
            end
         end
         default: begin
            state_next = IDLE;
            phase_next = 2'd0;
         end
      endcase

      // Abort wins over every transition and suppresses the done pulses.
      if (stop) begin
         state_next = IDLE;
         phase_next = 2'd0;
         phase_done = 1'b0;
         cycle_done = 1'b0;
      end
   end

endmodule

// File: tb/tb_control_contador_fases.sv
// tb/tb_control_contador_fases.sv - directed self-checking bench for control_contador_fases
// Includes a behavioural model of the external loadable up-counter.
module tb_control_contador_fases;

   logic       clk = 1'b0;
   logic       reset, start, stop, tick, hold, loop;
   logic [5:0] dur0, dur1, dur2, dur3;
   logic [5:0] cnt_in = 6'd37;
   logic       cnt_load, cnt_enable, busy, phase_done, cycle_done;
   logic [5:0] cnt_data;
   logic [1:0] phase;

   int n_assert = 0;
   int n_fail   = 0;

   control_contador_fases dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .tick(tick),
      .hold(hold), .loop(loop), .dur0(dur0), .dur1(dur1), .dur2(dur2),
      .dur3(dur3), .cnt_in(cnt_in), .cnt_load(cnt_load), .cnt_data(cnt_data),
      .cnt_enable(cnt_enable), .phase(phase), .busy(busy),
      .phase_done(phase_done), .cycle_done(cycle_done)
   );

   always #5 clk = ~clk;

   // External counter: load has priority over enable, never reset.
   always @(posedge clk) begin
      if (cnt_load)        cnt_in <= cnt_data;
      else if (cnt_enable) cnt_in <= cnt_in + 6'd1;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic next_clk;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; tick = 1'b0; hold = 1'b0; loop = 1'b0;
      dur0 = 6'd0; dur1 = 6'd0; dur2 = 6'd0; dur3 = 6'd0;
      next_clk;
      next_clk;
      chk("rst_busy", 8'(busy), 8'd0);
      chk("rst_phase", 8'(phase), 8'd0);
      chk("rst_load", 8'(cnt_load), 8'd0);
      chk("rst_enable", 8'(cnt_enable), 8'd0);
      chk("rst_pdone", 8'(phase_done), 8'd0);
      chk("rst_cdone", 8'(cycle_done), 8'd0);
      chk("rst_data", 8'(cnt_data), 8'd0);
      reset = 1'b0;

      // Full sequence 3,1,0,2: phases of 5,3,2,4 clocks
      dur0 = 6'd3; dur1 = 6'd1; dur2 = 6'd0; dur3 = 6'd2;
      tick = 1'b1; start = 1'b1;
      #1;
      chk("seq_idle_busy", 8'(busy), 8'd0);
      next_clk;
      for (int k = 1; k <= 15; k++) begin
         start = (k == 7);
         #1;
         chk($sformatf("seq_phase_%0d", k), 8'(phase),
             (k <= 5) ? 8'd0 : (k <= 8) ? 8'd1 : (k <= 10) ? 8'd2 : (k <= 14) ? 8'd3 : 8'd0);
         chk($sformatf("seq_busy_%0d", k), 8'(busy), (k <= 14) ? 8'd1 : 8'd0);
         chk($sformatf("seq_pdone_%0d", k), 8'(phase_done),
             (k == 5 || k == 8 || k == 10 || k == 14) ? 8'd1 : 8'd0);
         chk($sformatf("seq_cdone_%0d", k), 8'(cycle_done), (k == 14) ? 8'd1 : 8'd0);
         chk($sformatf("seq_load_%0d", k), 8'(cnt_load),
             (k == 1 || k == 6 || k == 9 || k == 11) ? 8'd1 : 8'd0);
         next_clk;
      end
      start = 1'b0;

      // Sparse ticks: every 4th clock, dur0=2
      dur0 = 6'd2; dur1 = 6'd0; dur2 = 6'd0; dur3 = 6'd0;
      tick = 1'b0; start = 1'b1;
      next_clk;
      start = 1'b0;
      #1;
      chk("tick_load", 8'(cnt_load), 8'd1);
      chk("tick_data", 8'(cnt_data), 8'd0);
      next_clk;
      for (int r = 0; r <= 8; r++) begin
         tick = (r % 4 == 3);
         #1;
         chk($sformatf("tick_en_%0d", r), 8'(cnt_enable), (r == 3 || r == 7) ? 8'd1 : 8'd0);
         chk($sformatf("tick_cnt_%0d", r), 8'(cnt_in), (r < 4) ? 8'd0 : (r < 8) ? 8'd1 : 8'd2);
         chk($sformatf("tick_pdone_%0d", r), 8'(phase_done), (r == 8) ? 8'd1 : 8'd0);
         next_clk;
      end
      tick = 1'b0; stop = 1'b1;
      #1;
      chk("tick_next_phase", 8'(phase), 8'd1);
      chk("tick_next_load", 8'(cnt_load), 8'd1);
      next_clk;
      stop = 1'b0;
      #1;
      chk("tick_stop_busy", 8'(busy), 8'd0);
      chk("tick_stop_phase", 8'(phase), 8'd0);

      // Hold freezes the counter at 1; start while busy is ignored
      dur0 = 6'd10; tick = 1'b1; start = 1'b1;
      next_clk;
      start = 1'b0;
      next_clk;
      next_clk;
      hold = 1'b1;
      for (int i = 0; i < 6; i++) begin
         start = 1'b1;
         #1;
         chk($sformatf("hold_en_%0d", i), 8'(cnt_enable), 8'd0);
         chk($sformatf("hold_cnt_%0d", i), 8'(cnt_in), 8'd1);
         chk($sformatf("hold_load_%0d", i), 8'(cnt_load), 8'd0);
         chk($sformatf("hold_phase_%0d", i), 8'(phase), 8'd0);
         next_clk;
      end
      start = 1'b0; hold = 1'b0;
      #1;
      chk("hold_release_en", 8'(cnt_enable), 8'd1);
      next_clk;
      chk("hold_release_cnt", 8'(cnt_in), 8'd2);
      stop = 1'b1;
      next_clk;
      stop = 1'b0;

      // Abort mid phase 2
      dur0 = 6'd1; dur1 = 6'd1; dur2 = 6'd5; dur3 = 6'd1; start = 1'b1;
      next_clk;
      start = 1'b0;
      for (int i = 0; i < 9; i++) next_clk;
      stop = 1'b1;
      #1;
      chk("abort_phase", 8'(phase), 8'd2);
      chk("abort_cnt", 8'(cnt_in), 8'd2);
      chk("abort_pdone", 8'(phase_done), 8'd0);
      next_clk;
      stop = 1'b0;
      #1;
      chk("abort_busy", 8'(busy), 8'd0);
      chk("abort_phase0", 8'(phase), 8'd0);

      // Stop on a phase-end cycle suppresses phase_done
      start = 1'b1;
      next_clk;
      start = 1'b0;
      next_clk;
      next_clk;
      stop = 1'b1;
      #1;
      chk("stop_end_cnt", 8'(cnt_in), 8'd1);
      chk("stop_end_pdone", 8'(phase_done), 8'd0);
      next_clk;
      stop = 1'b0;
      #1;
      chk("stop_end_busy", 8'(busy), 8'd0);

      // start and stop together in IDLE
      start = 1'b1; stop = 1'b1;
      next_clk;
      start = 1'b0; stop = 1'b0;
      #1;
      chk("start_stop_busy", 8'(busy), 8'd0);

      // Loop with dur0=63; mid-phase dur0 change ignored
      loop = 1'b1; dur0 = 6'd63; dur1 = 6'd0; dur2 = 6'd0; dur3 = 6'd0; tick = 1'b1;
      start = 1'b1;
      next_clk;
      start = 1'b0;
      next_clk;
      for (int r = 0; r <= 63; r++) begin
         if (r == 10) dur0 = 6'd5;
         #1;
         chk($sformatf("max_cnt_%0d", r), 8'(cnt_in), 8'(r));
         chk($sformatf("max_pdone_%0d", r), 8'(phase_done), (r == 63) ? 8'd1 : 8'd0);
         next_clk;
      end
      next_clk;
      chk("loop_p1_phase", 8'(phase), 8'd1);
      chk("loop_p1_pdone", 8'(phase_done), 8'd1);
      next_clk;
      next_clk;
      next_clk;
      next_clk;
      dur0 = 6'd20;
      #1;
      chk("loop_p3_phase", 8'(phase), 8'd3);
      chk("loop_p3_cdone", 8'(cycle_done), 8'd1);
      next_clk;
      chk("loop_back_phase", 8'(phase), 8'd0);
      chk("loop_back_busy", 8'(busy), 8'd1);
      chk("loop_back_load", 8'(cnt_load), 8'd1);
      for (int i = 0; i < 6; i++) next_clk;

      // Reset mid-RUN wins over stop and start
      reset = 1'b1; stop = 1'b1; start = 1'b1;
      #1;
      chk("midrun_cnt", 8'(cnt_in), 8'd5);
      chk("midrun_busy", 8'(busy), 8'd1);
      next_clk;
      reset = 1'b0; stop = 1'b0; start = 1'b0; loop = 1'b0;
      #1;
      chk("midrst_busy", 8'(busy), 8'd0);
      chk("midrst_phase", 8'(phase), 8'd0);
      chk("midrst_load", 8'(cnt_load), 8'd0);
      chk("midrst_enable", 8'(cnt_enable), 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
